// File: rtl/if_fetch.sv
// ----------------------------------------------------------------------------
// if_fetch : instruction-fetch stage of the 5-stage RV32I pipeline.
//
// Holds the PC and builds each 32-bit instruction from four little-endian
// byte reads on the byte-wide memory controller port. Decode-stage redirects
// (jump_flag_i/jump_addr_i) abort any fetch in flight. The presented word is
// held while the pipeline is stalled.
//
// Optional feature: define ICACHE_EN to add a direct-mapped instruction cache
// of ICACHE_LINES one-word lines. A hit presents the word one cycle after the
// IDLE lookup and makes no memory request.
//
// Ports
//   clk           in   rising-edge clock
//   rst           in   synchronous, active-high reset
//   stall_i       in   pipeline stall: hold output, start no new fetch
//   jump_flag_i   in   redirect request from decode
//   jump_addr_i   in   redirect target (word aligned internally)
//   mem_busy_i    in   memory controller busy; the current request is not accepted
//   mem_din_i     in   byte for the request accepted in the previous cycle
//   mem_req_o     out  byte fetch request
//   mem_addr_o    out  byte address of the request
//   pc_o          out  PC of inst_o
//   inst_o        out  fetched instruction
//   inst_valid_o  out  pc_o/inst_o valid for if_id
// ----------------------------------------------------------------------------
module if_fetch #(
   parameter int ADDR_W       = 32,
   parameter int INST_W       = 32,
   parameter int ICACHE_LINES = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_i,
   input  logic              jump_flag_i,
   input  logic [ADDR_W-1:0] jump_addr_i,
   input  logic              mem_busy_i,
   input  logic [7:0]        mem_din_i,
   output logic              mem_req_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [ADDR_W-1:0] pc_o,
   output logic [INST_W-1:0] inst_o,
   output logic              inst_valid_o
);

   typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

   state_t            state;
   logic [ADDR_W-1:0] pc;
   logic [2:0]        issue_cnt;
   logic [2:0]        recv_cnt;
   logic              byte_pending;
   logic [23:0]       byte_buf;

   logic              accept;
   logic              jump_take;
   logic              word_done;
   logic [ADDR_W-1:0] jump_target;
   logic [INST_W-1:0] word;
   logic              cache_hit;
   logic [INST_W-1:0] cache_word;
   logic              unused_jump_lsbs;

   // Elaboration-time guards: the assembly path is exactly four bytes wide,
   // and the cache index is a plain bit slice of the PC.
   generate
      if (INST_W != 32) begin : g_bad_inst_w
         $error("if_fetch: INST_W must be 32");
      end
      if ((ICACHE_LINES < 2) || ((ICACHE_LINES & (ICACHE_LINES - 1)) != 0)) begin : g_bad_lines
         $error("if_fetch: ICACHE_LINES must be a power of two >= 2");
      end
   endgenerate

   // The request is a pure decode of the registered state. The byte address
   // walks pc+0..pc+3 as requests are accepted and wraps modulo 2^ADDR_W.
   assign mem_req_o        = (state == FETCH) && (issue_cnt < 3'd4);
   assign mem_addr_o       = pc + ADDR_W'(issue_cnt);
   assign accept           = mem_req_o && !mem_busy_i;
   assign jump_take        = jump_flag_i && !stall_i;
   assign jump_target      = {jump_addr_i[ADDR_W-1:2], 2'b00};
   assign unused_jump_lsbs = ^jump_addr_i[1:0];

   // The fourth byte is merged straight from the bus, so the word is
   // presented the cycle after that byte arrives.
   assign word_done = (state == FETCH) && byte_pending && (recv_cnt == 3'd3);
   assign word      = {mem_din_i, byte_buf};

`ifdef ICACHE_EN
   localparam int IDX_W = $clog2(ICACHE_LINES);
   localparam int TAG_W = ADDR_W - 2 - IDX_W;

   logic [INST_W-1:0]       cache_data [ICACHE_LINES];
   logic [TAG_W-1:0]        cache_tag  [ICACHE_LINES];
   logic [ICACHE_LINES-1:0] cache_valid;
   logic [IDX_W-1:0]        pc_idx;
   logic [TAG_W-1:0]        pc_tag;
   logic                    cache_fill;

   assign pc_idx     = pc[2 +: IDX_W];
   assign pc_tag     = pc[ADDR_W-1 -: TAG_W];
   assign cache_hit  = cache_valid[pc_idx] && (cache_tag[pc_idx] == pc_tag);
   assign cache_word = cache_data[pc_idx];
   // A word aborted by a redirect or reset in its completion cycle never fills.
   assign cache_fill = word_done && !jump_take && !rst;

   // Data and tag storage carry no reset so they can map onto RAM.
   always_ff @(posedge clk) begin
      if (cache_fill) begin
         cache_data[pc_idx] <= word;
         cache_tag[pc_idx]  <= pc_tag;
      end
   end

   // Valid bits are the only cache state that reset has to clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         cache_valid <= '0;
      end else if (cache_fill) begin
         cache_valid[pc_idx] <= 1'b1;
      end
   end
`else
   assign cache_hit  = 1'b0;
   assign cache_word = '0;
`endif

   // Fetch FSM. Reset beats a redirect, and a redirect beats everything else,
   // including a word finishing in the same cycle. byte_pending remembers that
   // a request was accepted, so the byte arriving next cycle is captured even
   // if busy has risen by then; a redirect clears it so that byte is dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         pc           <= '0;
         issue_cnt    <= '0;
         recv_cnt     <= '0;
         byte_pending <= 1'b0;
         byte_buf     <= '0;
         pc_o         <= '0;
         inst_o       <= '0;
         inst_valid_o <= 1'b0;
      end else if (jump_take) begin
         state        <= IDLE;
         pc           <= jump_target;
         issue_cnt    <= '0;
         recv_cnt     <= '0;
         byte_pending <= 1'b0;
         inst_valid_o <= 1'b0;
      end else begin
         byte_pending <= accept;
         case (state)
            IDLE: begin
               if (!stall_i) begin
                  if (cache_hit) begin
                     state        <= DONE;
                     inst_o       <= cache_word;
                     pc_o         <= pc;
                     inst_valid_o <= 1'b1;
                  end else begin
                     state <= FETCH;
                  end
               end
            end
            FETCH: begin
               if (accept) begin
                  issue_cnt <= issue_cnt + 3'd1;
               end
               if (byte_pending) begin
                  recv_cnt <= recv_cnt + 3'd1;
                  case (recv_cnt[1:0])
                     2'd0:    byte_buf[7:0]   <= mem_din_i;
                     2'd1:    byte_buf[15:8]  <= mem_din_i;
                     2'd2:    byte_buf[23:16] <= mem_din_i;
                     default: begin
                        state        <= DONE;
                        inst_o       <= word;
                        pc_o         <= pc;
                        inst_valid_o <= 1'b1;
                     end
                  endcase
               end
            end
            DONE: begin
               if (!stall_i) begin
                  pc           <= pc + ADDR_W'(4);
                  state        <= IDLE;
                  issue_cnt    <= '0;
                  recv_cnt     <= '0;
                  inst_valid_o <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_if_fetch.sv
// ----------------------------------------------------------------------------
// tb_if_fetch : testbench for if_fetch.
//
// A byte memory is modelled as a fixed function of the address. The reference
// model tracks, per fetch, which PC should be presented next, how many byte
// requests have been accepted and how many bytes have been delivered, and from
// that decides when a word must become valid and what it must contain.
// Directed sequences cover reset, latency, stall hold, redirects, busy
// back-pressure, reset mid-fetch, address wrap and (with ICACHE_EN) cache
// hits; a randomised run follows.
// ----------------------------------------------------------------------------
module tb_if_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_i;
   logic        jump_flag_i;
   logic [31:0] jump_addr_i;
   logic        mem_busy_i;
   logic [7:0]  mem_din_i;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic [31:0] pc_o;
   logic [31:0] inst_o;
   logic        inst_valid_o;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   logic [31:0] expPc;
   int          issued;
   int          delivered;
   bit          pendValid;
   logic [31:0] pendAddr;
   bit          validDue;
   int          idleCycles;

`ifdef ICACHE_EN
   logic [31:0] mcAddr [64];
   bit          mcValid [64];
`endif

   always #5 clk = ~clk;

   if_fetch #(
      .ADDR_W(32),
      .INST_W(32),
      .ICACHE_LINES(64)
   ) dut (
      .clk(clk),
      .rst(rst),
      .stall_i(stall_i),
      .jump_flag_i(jump_flag_i),
      .jump_addr_i(jump_addr_i),
      .mem_busy_i(mem_busy_i),
      .mem_din_i(mem_din_i),
      .mem_req_o(mem_req_o),
      .mem_addr_o(mem_addr_o),
      .pc_o(pc_o),
      .inst_o(inst_o),
      .inst_valid_o(inst_valid_o)
   );

   // Memory contents: the first word is a fixed ADDI, everything else a hash.
   function automatic logic [7:0] memByte(input logic [31:0] a);
      logic [31:0] h;
      case (a)
         32'd0:   return 8'h13;
         32'd1:   return 8'h00;
         32'd2:   return 8'h50;
         32'd3:   return 8'h00;
         default: begin
            h = a * 32'h9E3779B1;
            return h[31:24] ^ h[7:0];
         end
      endcase
   endfunction

   function automatic logic [31:0] memWord(input logic [31:0] a);
      return {memByte(a + 32'd3), memByte(a + 32'd2), memByte(a + 32'd1), memByte(a)};
   endfunction

`ifdef ICACHE_EN
   function automatic bit modelHit(input logic [31:0] a);
      return mcValid[a[7:2]] && (mcAddr[a[7:2]] == a);
   endfunction
`endif

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
      end
   endtask

   task automatic modelReset();
      expPc     = 32'h0;
      issued    = 0;
      delivered = 0;
      pendValid = 1'b0;
      pendAddr  = 32'h0;
      validDue  = 1'b0;
`ifdef ICACHE_EN
      for (int i = 0; i < 64; i++) mcValid[i] = 1'b0;
`endif
   endtask

   // One clock cycle: drive inputs, check this cycle's outputs against the
   // model, advance the model, then move to just after the next rising edge.
   task automatic applyStimulus(input bit r, input bit s, input bit b, input bit j, input logic [31:0] ja);
      bit accept;
      bit jumpTaken;
      bit fourth;
      rst         = r;
      stall_i     = s;
      mem_busy_i  = b;
      jump_flag_i = j;
      jump_addr_i = ja;
      mem_din_i   = pendValid ? memByte(pendAddr) : 8'($urandom);

      if (mem_req_o) begin
         checkOutput("req_addr", mem_addr_o, expPc + 32'(issued));
         checkOutput("req_count", 32'(issued < 4), 32'd1);
      end
`ifdef ICACHE_EN
      if (inst_valid_o && !validDue) begin
         checkOutput("hit_legal", 32'(modelHit(expPc) && issued == 0), 32'd1);
      end else begin
         checkOutput("valid_timing", 32'(inst_valid_o), 32'(validDue));
      end
      if (mem_req_o && issued == 0) begin
         checkOutput("miss_only", 32'(modelHit(expPc)), 32'd0);
      end
`else
      checkOutput("valid_timing", 32'(inst_valid_o), 32'(validDue));
`endif
      if (inst_valid_o) begin
         checkOutput("valid_pc", pc_o, expPc);
         checkOutput("valid_inst", inst_o, memWord(expPc));
      end

      accept    = mem_req_o && !b;
      jumpTaken = j && !s;
      fourth    = pendValid && (delivered == 3);
      if (r) begin
         modelReset();
      end else if (jumpTaken) begin
         expPc     = {ja[31:2], 2'b00};
         issued    = 0;
         delivered = 0;
         pendValid = 1'b0;
         validDue  = 1'b0;
      end else begin
         validDue = fourth || (inst_valid_o && s);
         if (pendValid) delivered++;
`ifdef ICACHE_EN
         if (fourth) begin
            mcValid[expPc[7:2]] = 1'b1;
            mcAddr[expPc[7:2]]  = expPc;
         end
`endif
         pendValid = accept;
         pendAddr  = mem_addr_o;
         if (accept) issued++;
         if (inst_valid_o && !s) begin
            expPc     = expPc + 32'd4;
            issued    = 0;
            delivered = 0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic step();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic runUntilValid();
      for (int i = 0; i < 60 && !inst_valid_o; i++) step();
      checkOutput("reach_valid", 32'(inst_valid_o), 32'd1);
   endtask

   task automatic runUntilReq(input logic [31:0] addr);
      for (int i = 0; i < 60 && !(mem_req_o && mem_addr_o == addr); i++) step();
      checkOutput("reach_req", 32'(mem_req_o && mem_addr_o == addr), 32'd1);
   endtask

   // Hard stop in case something keeps the bench from its summary.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rst         = 1'b1;
      stall_i     = 1'b0;
      jump_flag_i = 1'b0;
      jump_addr_i = 32'h0;
      mem_busy_i  = 1'b0;
      mem_din_i   = 8'h0;
      modelReset();
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;

      // Reset values
      checkOutput("rst_valid", 32'(inst_valid_o), 32'd0);
      checkOutput("rst_inst", inst_o, 32'd0);
      checkOutput("rst_pc", pc_o, 32'd0);
      checkOutput("rst_req", 32'(mem_req_o), 32'd0);
      checkOutput("rst_addr", mem_addr_o, 32'd0);

      // First fetch: requests in cycles 0..3, word valid in cycle 5
      step();
      for (int k = 0; k < 4; k++) begin
         checkOutput("t1_req", 32'(mem_req_o), 32'd1);
         checkOutput("t1_addr", mem_addr_o, 32'(k));
         step();
      end
      checkOutput("t1_req_end", 32'(mem_req_o), 32'd0);
      step();
      checkOutput("t1_valid", 32'(inst_valid_o), 32'd1);
      checkOutput("t1_inst", inst_o, 32'h00500013);
      checkOutput("t1_pc", pc_o, 32'h0);

      // Three stalled cycles at DONE hold the word and issue nothing
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
         checkOutput("t2_hold_valid", 32'(inst_valid_o), 32'd1);
         checkOutput("t2_hold_inst", inst_o, 32'h00500013);
         checkOutput("t2_hold_pc", pc_o, 32'h0);
         checkOutput("t2_no_req", 32'(mem_req_o), 32'd0);
      end
      step();
      checkOutput("t2_consumed", 32'(inst_valid_o), 32'd0);
      checkOutput("t2_idle_req", 32'(mem_req_o), 32'd0);
      step();
      checkOutput("t2_next_req", 32'(mem_req_o), 32'd1);
      checkOutput("t2_next_addr", mem_addr_o, 32'h4);

      // Redirect to 0x103 after two bytes of pc 8 have arrived
      runUntilValid();
      checkOutput("t3_pc4", pc_o, 32'h4);
      step();
      runUntilReq(32'h8);
      step();
      step();
      checkOutput("t3_addr_a", mem_addr_o, 32'hA);
      step();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h103);
      checkOutput("t3_no_valid", 32'(inst_valid_o), 32'd0);
      checkOutput("t3_idle_req", 32'(mem_req_o), 32'd0);
      step();
      checkOutput("t3_target_req", 32'(mem_req_o), 32'd1);
      checkOutput("t3_target_addr", mem_addr_o, 32'h100);

      // Busy for two cycles after byte 1 is accepted: valid at cycle 7
      step();
      step();
      checkOutput("t4_busy_addr", mem_addr_o, 32'h102);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput("t4_retry_addr", mem_addr_o, 32'h102);
      step();
      step();
      checkOutput("t4_not_yet", 32'(inst_valid_o), 32'd0);
      step();
      checkOutput("t4_valid", 32'(inst_valid_o), 32'd1);
      checkOutput("t4_inst", inst_o, memWord(32'h100));
      checkOutput("t4_pc", pc_o, 32'h100);

      // Redirect while DONE drops the held word; then reset during byte 2 of 0x20
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h20);
      checkOutput("t6_drop_held", 32'(inst_valid_o), 32'd0);
      runUntilReq(32'h20);
      step();
      step();
      checkOutput("t6_byte2_addr", mem_addr_o, 32'h22);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput("t6_rst_valid", 32'(inst_valid_o), 32'd0);
      checkOutput("t6_rst_inst", inst_o, 32'd0);
      checkOutput("t6_rst_pc", pc_o, 32'd0);
      checkOutput("t6_rst_req", 32'(mem_req_o), 32'd0);
      checkOutput("t6_rst_addr", mem_addr_o, 32'd0);
      step();
      checkOutput("t6_refetch_req", 32'(mem_req_o), 32'd1);
      checkOutput("t6_refetch_addr", mem_addr_o, 32'h0);

      // Run 0x0, 0x4, 0x8, then redirect back to 0x0
      for (int k = 0; k < 3; k++) begin
         runUntilValid();
         checkOutput("t5_seq_pc", pc_o, 32'(4 * k));
         step();
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
      checkOutput("t5_idle_valid", 32'(inst_valid_o), 32'd0);
      checkOutput("t5_idle_req", 32'(mem_req_o), 32'd0);
      step();
`ifdef ICACHE_EN
      checkOutput("t5_hit_valid", 32'(inst_valid_o), 32'd1);
      checkOutput("t5_hit_pc", pc_o, 32'h0);
      checkOutput("t5_hit_no_req", 32'(mem_req_o), 32'd0);
`else
      checkOutput("t5_miss_req", 32'(mem_req_o), 32'd1);
      checkOutput("t5_miss_addr", mem_addr_o, 32'h0);
`endif

      // PC wrap: 0xFFFFFFFC + 4 continues at 0
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFD);
      runUntilValid();
      checkOutput("wrap_pc", pc_o, 32'hFFFFFFFC);
      step();
      runUntilReq(32'h0);

      // Randomised traffic
      idleCycles = 0;
      for (int n = 0; n < 3000; n++) begin
         bit          r;
         bit          s;
         bit          b;
         bit          j;
         logic [31:0] ja;
         r = ($urandom_range(0, 499) == 0);
         s = ($urandom_range(0, 3) == 0);
         b = ($urandom_range(0, 3) == 0);
         j = ($urandom_range(0, 39) == 0);
         case ($urandom_range(0, 3))
            0:       ja = 32'hFFFFFFF0 | 32'($urandom_range(0, 15));
            1:       ja = $urandom;
            default: ja = 32'($urandom_range(0, 255));
         endcase
         applyStimulus(r, s, b, j, ja);
         idleCycles = inst_valid_o ? 0 : idleCycles + 1;
         if (idleCycles > 400) begin
            checkOutput("progress", 32'(idleCycles), 32'd400);
            idleCycles = 0;
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
